pc_trace_monitor: RTL

PC_TRACE_MONITOR -- requirements
Module: pc_trace_monitor

---
 rtl/trace_pkg.sv | 18 +
 rtl/trace_fifo.sv | 76 +++++++
 rtl/pc_trace_monitor.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared trace-entry kind codes and entry layout for the PC trace monitor.
// Field widths are upper bounds; the monitor packs entries down to its own PC_W/DATA_W.
package trace_pkg;

  localparam logic [1:0] KIND_PC   = 2'b01;
  localparam logic [1:0] KIND_ST   = 2'b10;
  localparam logic [1:0] KIND_BOTH = 2'b11;

  localparam int TRACE_FIELD_MAX = 32;

  typedef struct packed {
    logic [1:0]                 kind;
    logic [TRACE_FIELD_MAX-1:0] pc;
    logic [TRACE_FIELD_MAX-1:0] addr;
    logic [TRACE_FIELD_MAX-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// First-word fall-through FIFO holding packed trace entries; DEPTH must be a power of two.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == {(AW+1){1'b0}});
  assign count = count_r;
  assign dout  = mem_r[rd_ptr_r];

  // A push into a full FIFO is only accepted when a pop frees a slot the same cycle.
  always_comb begin
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    if (pop && !empty) begin
      pop_ok_s = 1'b1;
    end else begin
      pop_ok_s = 1'b0;
    end
    if (push && (!full || pop_ok_s)) begin
      push_ok_s = 1'b1;
    end else begin
      push_ok_s = 1'b0;
    end
  end

  // Entry storage, written at the tail.
  always_ff @(posedge clk) begin
    if (push_ok_s && !reset) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pc_trace_monitor.sv
// Observes a CPU's PC and stores, logging PC changes (and stores when PC_TRACE_STORE_EN
// is defined) into a trace FIFO, with overflow, halt detection and an instruction counter.
module pc_trace_monitor
  import trace_pkg::*;
#(
  parameter int PC_W        = 9,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PC_W-1:0]            pc,
  input  logic                       pc_valid,
  input  logic                       mem_write,
  input  logic [DATA_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_wdata,
  input  logic                       rd_ready,
  input  logic                       clr_ovf,
  output logic                       rd_valid,
  output logic [1:0]                 rd_kind,
  output logic [PC_W-1:0]            rd_pc,
  output logic [DATA_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       halted,
  output logic [15:0]                instr_count
);

  localparam int IDLE_W = $clog2(HALT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(HALT_CYCLES);
`ifdef PC_TRACE_STORE_EN
  localparam int ENTRY_W = 2 + PC_W + 2*DATA_W;
`else
  localparam int ENTRY_W = 1 + PC_W;
`endif

  logic [PC_W-1:0]    prev_pc_r;
  logic               prev_ok_r;
  logic               pc_chg_s;
  logic               store_ev_s;
  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               empty_s;
  logic [1:0]         kind_s;
  trace_entry_t       push_entry_s;
  logic [ENTRY_W-1:0] fifo_din_s;
  logic [ENTRY_W-1:0] fifo_dout_s;
  logic [IDLE_W-1:0]  idle_r;
  logic               halted_r;
  logic               overflow_r;
  logic [15:0]        instr_count_r;
  logic               unused_s;

  assign pc_chg_s = pc_valid && prev_ok_r && (pc != prev_pc_r);
`ifdef PC_TRACE_STORE_EN
  assign store_ev_s = mem_write && pc_valid;
`else
  assign store_ev_s = 1'b0;
`endif
  assign push_s = pc_chg_s || store_ev_s;
  assign pop_s  = !empty_s && rd_ready;

  // Build the entry for this cycle's event; addr/data stay zero unless a store is logged.
  always_comb begin
    kind_s       = 2'b00;
    push_entry_s = '0;
    case ({store_ev_s, pc_chg_s})
      2'b01:   kind_s = KIND_PC;
      2'b10:   kind_s = KIND_ST;
      2'b11:   kind_s = KIND_BOTH;
      default: kind_s = 2'b00;
    endcase
    push_entry_s.kind = kind_s;
    push_entry_s.pc   = TRACE_FIELD_MAX'(pc);
    if (store_ev_s) begin
      push_entry_s.addr = TRACE_FIELD_MAX'(mem_addr);
      push_entry_s.data = TRACE_FIELD_MAX'(mem_wdata);
    end else begin
      push_entry_s.addr = '0;
      push_entry_s.data = '0;
    end
  end

`ifdef PC_TRACE_STORE_EN
  assign fifo_din_s = {push_entry_s.kind, push_entry_s.pc[PC_W-1:0],
                       push_entry_s.addr[DATA_W-1:0], push_entry_s.data[DATA_W-1:0]};
  assign rd_kind = fifo_dout_s[ENTRY_W-1 -: 2];
  assign rd_pc   = fifo_dout_s[2*DATA_W +: PC_W];
  assign rd_addr = fifo_dout_s[DATA_W +: DATA_W];
  assign rd_data = fifo_dout_s[0 +: DATA_W];
`else
  assign fifo_din_s = {push_entry_s.kind[0], push_entry_s.pc[PC_W-1:0]};
  assign rd_kind = {1'b0, fifo_dout_s[PC_W]};
  assign rd_pc   = fifo_dout_s[PC_W-1:0];
  assign rd_addr = {DATA_W{1'b0}};
  assign rd_data = {DATA_W{1'b0}};
`endif
  // Collects bits that are intentionally left unread (upper struct bits, disabled store inputs).
  assign unused_s = ^{mem_write, push_entry_s};

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (fifo_din_s),
    .dout  (fifo_dout_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count)
  );

  // PC history, idle/halt tracking, instruction counter and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pc_r     <= {PC_W{1'b0}};
      prev_ok_r     <= 1'b0;
      idle_r        <= {IDLE_W{1'b0}};
      halted_r      <= 1'b0;
      overflow_r    <= 1'b0;
      instr_count_r <= 16'h0000;
    end else begin
      prev_pc_r <= pc;
      prev_ok_r <= pc_valid;
      halted_r  <= !pc_chg_s && (idle_r == IDLE_MAX);
      if (pc_chg_s) begin
        idle_r <= {IDLE_W{1'b0}};
      end else if (pc_valid && (idle_r != IDLE_MAX)) begin
        idle_r <= idle_r + {{(IDLE_W-1){1'b0}}, 1'b1};
      end
      if (pc_chg_s && (instr_count_r != 16'hFFFF)) begin
        instr_count_r <= instr_count_r + 16'h0001;
      end
      if (push_s && full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign rd_valid    = !empty_s;
  assign overflow    = overflow_r;
  assign halted      = halted_r;
  assign instr_count = instr_count_r;

endmodule
